// File: rtl/tick_pkg.sv
// Shared mode encodings, default divisor and width helpers for the tick timer bank.
package tick_pkg;

  localparam logic [1:0] MODE_PERIODIC = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_TOGGLE   = 2'b10;

  // 10 Hz tick from the 50 MHz system clock.
  localparam logic [31:0] DEF_DIV = 32'd5000000;

  function automatic int clog2(input int unsigned n);
    int r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) r = r + 1;
    return r;
  endfunction

  function automatic int chw(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/tick_timer_bank_if.sv
// Control and status bundle of the tick timer bank; master drives controls, slave is the bank.
interface tick_timer_bank_if import tick_pkg::*; #(
  parameter int N_CH = 4,
  parameter int W    = 32
);

  localparam int CHW = chw(N_CH);

  logic [N_CH-1:0]   en;
  logic [2*N_CH-1:0] mode;
  logic              clr;
  logic              ld;
  logic [CHW-1:0]    ld_ch;
  logic [W-1:0]      ld_val;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   level;
  logic [N_CH-1:0]   done;
  logic              tick_any;

  modport master (
    output en, mode, clr, ld, ld_ch, ld_val,
    input  tick, level, done, tick_any
  );

  modport slave (
    input  en, mode, clr, ld, ld_ch, ld_val,
    output tick, level, done, tick_any
  );

endinterface

// File: rtl/tick_channel.sv
// One tick channel: runtime divisor, enable-gated counter, periodic/one-shot/toggle output.
module tick_channel import tick_pkg::*; #(
  parameter int           W       = 32,
  parameter logic [W-1:0] DEF_DIV = W'(tick_pkg::DEF_DIV)
) (
  input  logic         cin,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic         tick,
  output logic         level,
  output logic         done,
  output logic         fire
);

  logic [W-1:0] count;
  logic [W-1:0] div;
  logic [W-1:0] term;
  logic [1:0]   eff_mode;

  // fire is the next-state tick; clr and ld outrank terminal count and swallow it.
  always_comb begin
    eff_mode = (mode == 2'b11) ? MODE_PERIODIC : mode;
    term     = (div == '0) ? '0 : div - 1'b1;
    fire     = !clr && !ld && en && !done && (count >= term);
  end

  always_ff @(posedge cin or posedge rst) begin
    if (rst) begin
      count <= '0;
      div   <= DEF_DIV;
      tick  <= 1'b0;
      level <= 1'b0;
      done  <= 1'b0;
    end else begin
      tick <= fire;
      if (clr) begin
        count <= '0;
        done  <= 1'b0;
      end else if (ld) begin
        div   <= ld_val;
        count <= '0;
        done  <= 1'b0;
      end else if (!en) begin
        count <= '0;
        done  <= 1'b0;
      end else if (!done) begin
        if (fire) begin
          count <= '0;
          if (eff_mode == MODE_ONESHOT) done <= 1'b1;
        end else begin
          count <= count + 1'b1;
        end
      end
      // Level only lives in toggle mode; leaving it drops the wave to 0.
      if (eff_mode != MODE_TOGGLE) level <= 1'b0;
      else if (fire)               level <= ~level;
    end
  end

endmodule

// File: rtl/tick_timer_bank.sv
// N_CH-channel tick generator: load decode, clr fan-out and the registered tick_any.
module tick_timer_bank import tick_pkg::*; #(
  parameter int           N_CH    = 4,
  parameter int           W       = 32,
  parameter logic [W-1:0] DEF_DIV = W'(tick_pkg::DEF_DIV)
) (
  input logic              cin,
  input logic              rst,
  tick_timer_bank_if.slave bus
);

  logic [N_CH-1:0] ld_sel;
  logic [N_CH-1:0] fire;
  logic [N_CH-1:0] tick_v;
  logic [N_CH-1:0] level_v;
  logic [N_CH-1:0] done_v;
  logic            tick_any_r;

  // Out-of-range channel indices match no channel, so such loads are dropped.
  always_comb begin
    ld_sel = '0;
    for (int unsigned i = 0; i < N_CH; i++)
      ld_sel[i] = bus.ld && (32'(bus.ld_ch) == i);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    tick_channel #(
      .W       (W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .cin    (cin),
      .rst    (rst),
      .en     (bus.en[g]),
      .mode   (bus.mode[2*g +: 2]),
      .clr    (bus.clr),
      .ld     (ld_sel[g]),
      .ld_val (bus.ld_val),
      .tick   (tick_v[g]),
      .level  (level_v[g]),
      .done   (done_v[g]),
      .fire   (fire[g])
    );
  end

  always_ff @(posedge cin or posedge rst) begin
    if (rst) tick_any_r <= 1'b0;
    else     tick_any_r <= |fire;
  end

  assign bus.tick     = tick_v;
  assign bus.level    = level_v;
  assign bus.done     = done_v;
  assign bus.tick_any = tick_any_r;

endmodule

// File: tb/tb_tick_timer_bank.sv
// Randomised and directed check of tick_timer_bank against a cycle-level behavioural model.
module tb_tick_timer_bank;
  import tick_pkg::*;

  logic cin = 1'b0;
  logic rst;
  always #10 cin = ~cin;

  tick_timer_bank_if #(.N_CH(4), .W(32)) bus ();
  tick_timer_bank_if #(.N_CH(3), .W(8))  bus2 ();

  tick_timer_bank #(.N_CH(4), .W(32), .DEF_DIV(32'd4)) dut (
    .cin (cin),
    .rst (rst),
    .bus (bus)
  );

  tick_timer_bank #(.N_CH(3), .W(8), .DEF_DIV(8'd4)) dut2 (
    .cin (cin),
    .rst (rst),
    .bus (bus2)
  );

  int total = 0;
  int bad   = 0;

  int unsigned m_cnt [4];
  int unsigned m_div [4];
  bit          m_done[4];
  bit          m_lvl [4];
  bit          m_tick[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_div[i] = 4; m_done[i] = 0; m_lvl[i] = 0; m_tick[i] = 0;
    end
  endtask

  // Channel i ticks when this enabled edge is the D-th counted since its last restart.
  task automatic model_edge();
    for (int i = 0; i < 4; i++) begin
      int unsigned d;
      bit          ldh, run, fire;
      logic [1:0]  md;
      md   = bus.mode[2*i +: 2];
      ldh  = bus.ld && (int'(bus.ld_ch) == i);
      d    = (m_div[i] == 0) ? 1 : m_div[i];
      run  = bus.en[i] && !m_done[i] && !bus.clr && !ldh;
      fire = run && (m_cnt[i] + 1 >= d);
      m_tick[i] = fire;
      if (md == 2'b10) m_lvl[i] = m_lvl[i] ^ fire;
      else             m_lvl[i] = 0;
      if (bus.clr || !bus.en[i]) begin
        m_cnt[i] = 0; m_done[i] = 0;
      end else if (ldh) begin
        m_div[i] = bus.ld_val; m_cnt[i] = 0; m_done[i] = 0;
      end else if (run) begin
        m_cnt[i] = fire ? 0 : m_cnt[i] + 1;
        if (fire && md == 2'b01) m_done[i] = 1;
      end
      if (ldh && !bus.clr && bus.en[i]) begin
        m_div[i] = bus.ld_val; m_cnt[i] = 0; m_done[i] = 0;
      end
      if (ldh && !bus.clr && !bus.en[i]) m_div[i] = bus.ld_val;
    end
  endtask

  task automatic step();
    logic [3:0] et, el, ed;
    @(posedge cin);
    model_edge();
    #1;
    for (int i = 0; i < 4; i++) begin
      et[i] = m_tick[i]; el[i] = m_lvl[i]; ed[i] = m_done[i];
    end
    chk("tick", bus.tick, et);
    chk("level", bus.level, el);
    chk("done", bus.done, ed);
    chk("tick_any", bus.tick_any, |et);
  endtask

  task automatic load(input int ch, input int unsigned val);
    bus.ld = 1'b1; bus.ld_ch = 2'(ch); bus.ld_val = val;
    step();
    bus.ld = 1'b0;
  endtask

  initial begin
    bus.en = '0; bus.mode = '0; bus.clr = 1'b0; bus.ld = 1'b0; bus.ld_ch = '0; bus.ld_val = '0;
    bus2.en = '0; bus2.mode = '0; bus2.clr = 1'b0; bus2.ld = 1'b0; bus2.ld_ch = '0; bus2.ld_val = '0;
    rst = 1'b1;
    #25;
    chk("rst_tick", bus.tick, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_any", bus.tick_any, 0);
    model_reset();
    rst = 1'b0;

    // Periodic, default divisor 4 on channel 0.
    bus.en = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t1_tick0", bus.tick[0], (k % 4 == 0));
      chk("t1_others", bus.tick[3:1], 0);
    end

    // One-shot with divisor 5.
    bus.en = '0; bus.mode = 8'b0000_0001;
    load(0, 5);
    bus.en = 4'b0001;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("t2_tick0", bus.tick[0], (k == 5));
      chk("t2_done0", bus.done[0], (k >= 5));
    end
    bus.en = '0;
    step();
    chk("t2_done_clr", bus.done[0], 0);
    bus.en = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t2_retick", bus.tick[0], (k == 5));
    end

    // Toggle on channel 2 with divisor 3.
    bus.en = '0; bus.mode = '0;
    load(2, 3);
    bus.mode[5:4] = 2'b10;
    bus.en = 4'b0100;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t3_tick2", bus.tick[2], (k % 3 == 0));
      chk("t3_level2", bus.level[2], ((k / 3) % 2));
    end

    // Load landing on the terminal-count edge.
    bus.en = '0; bus.mode = '0;
    step();
    load(0, 4);
    bus.en = 4'b0001;
    for (int k = 1; k <= 3; k++) step();
    load(0, 2);
    chk("t4_collide", bus.tick[0], 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t4_div2", bus.tick[0], (k % 2 == 0));
    end

    // Out-of-range channel index on a 3-channel bank is ignored.
    bus.en = '0;
    bus2.en = 3'b111;
    for (int k = 1; k <= 8; k++) begin
      bus2.ld = (k == 2); bus2.ld_ch = 2'd3; bus2.ld_val = 8'd2;
      step();
      chk("t4_oob_tick", bus2.tick, (k % 4 == 0) ? 3'b111 : 3'b000);
      chk("t4_oob_any", bus2.tick_any, (k % 4 == 0));
    end
    bus2.ld = 1'b0; bus2.en = '0;

    // Divisors 0 and 1, then clr phase alignment.
    load(0, 0);
    load(1, 1);
    bus.en = 4'b0011;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t5_d01", bus.tick[1:0], 2'b11);
    end
    load(2, 3);
    load(3, 3);
    bus.en = 4'b0111;
    step(); step();
    bus.en = 4'b1111;
    step(); step();
    bus.clr = 1'b1;
    step();
    chk("t5_clr", bus.tick, 0);
    bus.clr = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk("t5_align", bus.tick[3], bus.tick[2]);
      chk("t5_tick2", bus.tick[2], (k % 3 == 0));
    end

    // Randomised traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) bus.en[i] = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) bus.mode = 8'($urandom);
      bus.clr = ($urandom_range(0, 49) == 0);
      bus.ld  = ($urandom_range(0, 19) == 0);
      bus.ld_ch  = 2'($urandom_range(0, 3));
      bus.ld_val = $urandom_range(0, 9);
      step();
    end
    bus.clr = 1'b0; bus.ld = 1'b0; bus.mode = 8'b0000_1000; bus.en = 4'b0011;
    step(); step(); step();

    // Asynchronous reset between edges.
    #3 rst = 1'b1;
    #1;
    chk("t6_tick", bus.tick, 0);
    chk("t6_level", bus.level, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_any", bus.tick_any, 0);
    model_reset();
    #2 rst = 1'b0;
    bus.mode = '0; bus.en = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t6_defdiv", bus.tick[0], (k % 4 == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
